// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end.
// Owns the PC, drives the instruction-memory address (pc_out), and captures each fetched
// instruction into the IF/ID register. Stall holds PC and IF/ID. Redirect loads a new
// word-aligned PC and flushes IF/ID for one cycle.
// Optional branch target buffer, enabled by defining FETCH_BTB_EN. It is direct-mapped,
// looked up combinationally on pc_out, and trained by the execute stage through upd_*.
// Ports:
//   clk, reset          : clock and asynchronous active-high reset
//   stall               : hold PC and IF/ID
//   redirect_valid/_pc  : redirect fetch; the target is forced word-aligned
//   instr_in            : instruction read combinationally at pc_out
//   upd_*               : BTB training (ignored when FETCH_BTB_EN is undefined)
//   pc_out              : current PC / instruction-memory address
//   if_id_*             : IF/ID pipeline register contents
module fetch_unit #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       BTB_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic [31:0]       instr_in,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  output logic [ADDR_W-1:0] pc_out,
  output logic [31:0]       if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [ADDR_W-1:0] if_id_pc_plus4,
  output logic              if_id_valid,
  output logic              if_id_pred_taken
);

  localparam logic [ADDR_W-1:0] ResetPcAligned = {RESET_PC[ADDR_W-1:2], 2'b00};

  logic [ADDR_W-1:0] pc_q, pc_d, pc_plus4;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;

  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] ifpc_q, ifpc4_q;
  logic              valid_q, pred_q;

  assign pc_plus4 = pc_q + ADDR_W'(4);

`ifdef FETCH_BTB_EN
  localparam int unsigned IdxW = $clog2(BTB_DEPTH);
  localparam int unsigned TagW = ADDR_W - IdxW - 2;

  logic [BTB_DEPTH-1:0] btb_valid_q;
  logic [TagW-1:0]      btb_tag_q    [BTB_DEPTH];
  logic [ADDR_W-1:0]    btb_target_q [BTB_DEPTH];
  logic [1:0]           btb_cnt_q    [BTB_DEPTH];

  logic [IdxW-1:0] lk_idx, up_idx;
  logic [TagW-1:0] lk_tag, up_tag;
  logic            up_hit;
  logic            unused_bits;

  assign lk_idx = pc_q[IdxW+1:2];
  assign lk_tag = pc_q[ADDR_W-1:IdxW+2];
  assign up_idx = upd_pc[IdxW+1:2];
  assign up_tag = upd_pc[ADDR_W-1:IdxW+2];

  // Lookup sees the registered contents, so a same-cycle update is only visible next cycle.
  assign pred_taken  = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag) &&
                       btb_cnt_q[lk_idx][1];
  assign pred_target = btb_target_q[lk_idx];
  assign up_hit      = btb_valid_q[up_idx] && (btb_tag_q[up_idx] == up_tag);

  assign unused_bits = ^{redirect_pc[1:0], upd_pc[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btb_valid_q <= '0;
      for (int i = 0; i < int'(BTB_DEPTH); i++) begin
        btb_tag_q[i]    <= '0;
        btb_target_q[i] <= '0;
        btb_cnt_q[i]    <= '0;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          if (btb_cnt_q[up_idx] != 2'b11) btb_cnt_q[up_idx] <= btb_cnt_q[up_idx] + 2'd1;
          btb_target_q[up_idx] <= upd_target;
        end else if (btb_cnt_q[up_idx] != 2'b00) begin
          btb_cnt_q[up_idx] <= btb_cnt_q[up_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        // Allocate weakly taken, overwriting whatever occupied the slot.
        btb_valid_q[up_idx]  <= 1'b1;
        btb_tag_q[up_idx]    <= up_tag;
        btb_target_q[up_idx] <= upd_target;
        btb_cnt_q[up_idx]    <= 2'b10;
      end
    end
  end
`else
  logic unused_bits;

  assign pred_taken  = 1'b0;
  assign pred_target = pc_plus4;
  assign unused_bits = ^{redirect_pc[1:0], upd_valid, upd_pc, upd_taken, upd_target, BTB_DEPTH};
`endif

  always_comb begin
    pc_d = pc_plus4;
    if (redirect_valid) begin
      pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (stall) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = pred_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= ResetPcAligned;
      instr_q <= '0;
      ifpc_q  <= '0;
      ifpc4_q <= '0;
      valid_q <= 1'b0;
      pred_q  <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (redirect_valid) begin
        // Only the valid bit matters on a flush; the other fields keep their old data.
        valid_q <= 1'b0;
      end else if (!stall) begin
        instr_q <= instr_in;
        ifpc_q  <= pc_q;
        ifpc4_q <= pc_plus4;
        valid_q <= 1'b1;
        pred_q  <= pred_taken;
      end
    end
  end

  assign pc_out           = pc_q;
  assign if_id_instr      = instr_q;
  assign if_id_pc         = ifpc_q;
  assign if_id_pc_plus4   = ifpc4_q;
  assign if_id_valid      = valid_q;
  assign if_id_pred_taken = pred_q;

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int unsigned Depth = 16;
  localparam int unsigned IdxW  = 4;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid, upd_valid, upd_taken;
  logic [31:0] redirect_pc, upd_pc, upd_target;
  logic [31:0] instr_in, pc_out, if_id_instr, if_id_pc, if_id_pc_plus4;
  logic        if_id_valid, if_id_pred_taken;
  logic [31:0] instr_w, pc_w, instr_q_w, ifpc_w, ifpc4_w;
  logic        valid_w, pred_w;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  assign instr_in = mem_word(pc_out);
  assign instr_w  = mem_word(pc_w);

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .BTB_DEPTH(Depth)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_in(instr_in), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .pc_out(pc_out),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid), .if_id_pred_taken(if_id_pred_taken)
  );

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .BTB_DEPTH(Depth)) u_wrap (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_in(instr_w), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .pc_out(pc_w),
    .if_id_instr(instr_q_w), .if_id_pc(ifpc_w), .if_id_pc_plus4(ifpc4_w),
    .if_id_valid(valid_w), .if_id_pred_taken(pred_w)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: fetch state plus the BTB as a sparse map from index to entry.
  typedef struct {
    logic [31:0] tag;
    logic [31:0] target;
    int          cnt;
  } btb_ent_t;

  btb_ent_t    btb [int];
  logic [31:0] m_pc, m_ifpc, m_instr;
  bit          m_valid, m_pred;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % Depth);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a >> (IdxW + 2);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_ifpc = 32'h0; m_instr = 32'h0; m_valid = 1'b0; m_pred = 1'b0;
    btb.delete();
  endtask

  task automatic model_step();
    bit          pt;
    logic [31:0] tgt, nxt;
    int          i;
    btb_ent_t    e;
    pt  = 1'b0;
    tgt = 32'h0;
`ifdef FETCH_BTB_EN
    i = idx_of(m_pc);
    if (btb.exists(i) && btb[i].tag == tag_of(m_pc) && btb[i].cnt >= 2) begin
      pt  = 1'b1;
      tgt = btb[i].target;
    end
`endif
    if (redirect_valid) nxt = redirect_pc & ~32'h3;
    else if (stall)     nxt = m_pc;
    else if (pt)        nxt = tgt;
    else                nxt = m_pc + 32'd4;
    if (redirect_valid) m_valid = 1'b0;
    else if (!stall) begin
      m_valid = 1'b1; m_ifpc = m_pc; m_instr = mem_word(m_pc); m_pred = pt;
    end
`ifdef FETCH_BTB_EN
    if (upd_valid) begin
      i = idx_of(upd_pc);
      if (btb.exists(i) && btb[i].tag == tag_of(upd_pc)) begin
        e = btb[i];
        if (upd_taken) begin
          e.cnt    = (e.cnt < 3) ? e.cnt + 1 : 3;
          e.target = upd_target;
        end else begin
          e.cnt = (e.cnt > 0) ? e.cnt - 1 : 0;
        end
        btb[i] = e;
      end else if (upd_taken) begin
        e.tag = tag_of(upd_pc); e.target = upd_target; e.cnt = 2;
        btb[i] = e;
      end
    end
`endif
    m_pc = nxt;
  endtask

  task automatic drive(input bit s, input bit rv, input logic [31:0] rpc, input bit uv,
                       input logic [31:0] upc, input bit ut, input logic [31:0] utgt);
    stall = s; redirect_valid = rv; redirect_pc = rpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check({tag, " pc"}, pc_out, m_pc);
    check({tag, " valid"}, {31'b0, if_id_valid}, {31'b0, m_valid});
    if (m_valid) begin
      check({tag, " if_pc"}, if_id_pc, m_ifpc);
      check({tag, " if_pc4"}, if_id_pc_plus4, m_ifpc + 32'd4);
      check({tag, " instr"}, if_id_instr, m_instr);
      check({tag, " pred"}, {31'b0, if_id_pred_taken}, {31'b0, m_pred});
    end
  endtask

  // Reset is raised mid-cycle, away from any clock edge, so outputs must change at once.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    check("rst pc", pc_out, 32'h0);
    check("rst valid", {31'b0, if_id_valid}, 32'h0);
    check("rst pred", {31'b0, if_id_pred_taken}, 32'h0);
    check("rst if_pc", if_id_pc, 32'h0);
    check("rst if_pc4", if_id_pc_plus4, 32'h0);
    check("rst instr", if_id_instr, 32'h0);
    check("rst wrap pc", pc_w, 32'hFFFF_FFFC);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit          s;
    bit          rv;
    logic [31:0] rpc;
    logic [31:0] e_pc;
    bit          e_v;
    logic [31:0] e_ifpc;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{0, 0, 32'h0,   32'h4,   1, 32'h0};
    vt[1] = '{0, 0, 32'h0,   32'h8,   1, 32'h4};
    vt[2] = '{1, 0, 32'h0,   32'h8,   1, 32'h4};
    vt[3] = '{1, 0, 32'h0,   32'h8,   1, 32'h4};
    vt[4] = '{0, 0, 32'h0,   32'hC,   1, 32'h8};
    vt[5] = '{1, 1, 32'h103, 32'h100, 0, 32'h0};
    vt[6] = '{0, 0, 32'h0,   32'h104, 1, 32'h100};
    vt[7] = '{0, 0, 32'h0,   32'h108, 1, 32'h104};

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    do_reset();

    for (int k = 0; k < 8; k++) begin
      drive(vt[k].s, vt[k].rv, vt[k].rpc, 0, 0, 0, 0);
      tick($sformatf("vec%0d", k));
      check($sformatf("vec%0d tbl pc", k), pc_out, vt[k].e_pc);
      check($sformatf("vec%0d tbl valid", k), {31'b0, if_id_valid}, {31'b0, vt[k].e_v});
      if (vt[k].e_v) begin
        check($sformatf("vec%0d tbl if_pc", k), if_id_pc, vt[k].e_ifpc);
        check($sformatf("vec%0d tbl if_pc4", k), if_id_pc_plus4, vt[k].e_ifpc + 32'd4);
      end
      if (k == 0) begin
        check("wrap pc", pc_w, 32'h0);
        check("wrap if_pc", ifpc_w, 32'hFFFF_FFFC);
        check("wrap if_pc4", ifpc4_w, 32'h0);
        check("wrap valid", {31'b0, valid_w}, 32'h1);
      end
    end

`ifdef FETCH_BTB_EN
    // Train 0x10 -> 0x40, fetch through it, then weaken it to strongly not-taken.
    do_reset();
    drive(0, 0, 0, 1, 32'h10, 1, 32'h40);
    tick("trn0");
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) tick("trn1");
    check("btb taken pc", pc_out, 32'h40);
    check("btb taken if_pc", if_id_pc, 32'h10);
    check("btb taken pred", {31'b0, if_id_pred_taken}, 32'h1);
    drive(0, 0, 0, 1, 32'h10, 0, 32'h0);
    tick("trn2");
    tick("trn3");
    drive(0, 1, 32'h10, 0, 0, 0, 0);
    tick("trn4");
    drive(0, 0, 0, 0, 0, 0, 0);
    tick("trn5");
    check("btb nt pc", pc_out, 32'h14);
    check("btb nt pred", {31'b0, if_id_pred_taken}, 32'h0);

    // Same-cycle lookup and update at index 4: the lookup sees the old entry.
    do_reset();
    drive(0, 1, 32'h10, 0, 0, 0, 0);
    tick("sc0");
    drive(0, 0, 0, 1, 32'h10, 1, 32'h80);
    tick("sc1");
    check("same-cycle alloc pc", pc_out, 32'h14);
    drive(0, 1, 32'h10, 0, 0, 0, 0);
    tick("sc2");
    drive(0, 0, 0, 1, 32'h10, 0, 32'h0);
    tick("sc3");
    check("same-cycle old entry pc", pc_out, 32'h80);
    check("same-cycle old entry pred", {31'b0, if_id_pred_taken}, 32'h1);
    drive(0, 1, 32'h10, 0, 0, 0, 0);
    tick("sc4");
    drive(0, 0, 0, 0, 0, 0, 0);
    tick("sc5");
    check("same-cycle new entry pc", pc_out, 32'h14);
`endif

    // Random traffic against the model, with a reset in the middle of the run.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      logic [31:0] upc;
      if (n == 400) do_reset();
      upc = ($urandom % 8 == 0) ? 32'h1000 + ($urandom_range(0, 31) << 2)
                                : ($urandom_range(0, 63) << 2);
      drive($urandom % 4 == 0, $urandom % 12 == 0, $urandom_range(0, 255),
            $urandom % 3 == 0, upc, $urandom % 3 != 0, $urandom_range(0, 63) << 2);
      tick("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the pipelined core. It owns the program counter, drives the instruction-memory address, and captures each fetched instruction into the IF/ID pipeline register. It accepts stall and redirect requests from later stages. It can also predict taken branches through an optional branch target buffer (BTB) that is trained by the execute stage.

## Interface
- ADDR_W, default 32: PC and address width, in bits.
- RESET_PC, default 32'h0000_0000: PC value loaded on reset. Bits [1:0] are treated as zero.
- BTB_DEPTH, default 16: number of BTB entries. Must be a power of two and at least 2. IDX_W = log2(BTB_DEPTH).

Ports:
- clk  in  1  : single clock; all state is rising-edge triggered.
- reset  in  1  : asynchronous, active-high reset.
- stall  in  1  : hold the PC and IF/ID contents.
- redirect_valid  in  1  : later stage redirects fetch (mispredict, jump or branch resolution).
- redirect_pc  in  ADDR_W  : redirect target.
- instr_in  in  32  : instruction read combinationally from instruction memory at pc_out.
- upd_valid  in  1  : BTB training event from execute.
- upd_pc  in  ADDR_W  : PC of the resolved branch.
- upd_taken  in  1  : resolved direction of the branch.
- upd_target  in  ADDR_W  : resolved target of the branch.
- pc_out  out  ADDR_W  : current PC, used as the instruction-memory address.
- if_id_instr  out  32  : latched instruction.
- if_id_pc  out  ADDR_W  : PC of the latched instruction.
- if_id_pc_plus4  out  ADDR_W  : if_id_pc + 4.
- if_id_valid  out  1  : IF/ID holds a real instruction (not a bubble).
- if_id_pred_taken  out  1  : fetch predicted this instruction taken.

## Operation
- Next-PC selection, highest priority first:
  - redirect_valid: {redirect_pc[ADDR_W-1:2],2'b00}.
  - stall: PC unchanged.
  - Predicted-taken BTB hit: stored target.
  - Otherwise: PC+4.
- PC arithmetic is modulo 2^ADDR_W. PC+4 wraps silently.
- IF/ID update, highest priority first:
  - redirect_valid: if_id_valid<=0. The wrong-path instruction is flushed; the other IF/ID fields are don't-care.
  - stall: all IF/ID fields hold.
  - Otherwise: load instr_in, PC, PC+4 and the prediction bit, and set if_id_valid<=1.
- BTB entry contents: valid bit, tag, target, 2-bit saturating counter.
  - Index = PC[IDX_W+1:2]. Tag = PC[ADDR_W-1:IDX_W+2].
  - Hit = valid bit set and tag matches.
  - Predict taken when hit and counter[1]=1.
- Update on upd_valid:
  - Tag hit: counter increments on taken, decrements on not-taken, saturating at 2'b11 and 2'b00. On taken, target <= upd_target.
  - Miss with upd_taken=1: allocate the entry (overwrite), valid=1, counter=2'b10.
  - Miss with upd_taken=0: no change.
- Simultaneous lookup and update of the same index: lookup uses the pre-update contents. The update is visible on the next cycle.
- Reset mid-operation asynchronously forces every output to its reset value and clears all BTB valid bits. Any in-flight redirect or update is dropped.
- Reset values:
  - pc_out=RESET_PC.
  - if_id_instr=0, if_id_pc=0, if_id_pc_plus4=0.
  - if_id_valid=0, if_id_pred_taken=0.

## Timing
- pc_out is a register output. instr_in must settle within the same cycle (asynchronous-read memory).
- Fetch-to-IF/ID latency: 1 cycle. Redirect-to-new-pc_out latency: 1 cycle. Redirect bubble: exactly 1 invalid IF/ID cycle.
- Throughput: one instruction per cycle when stall=0 and redirect_valid=0.
- BTB lookup is combinational on pc_out. BTB update takes effect at the next rising edge.

## Configuration
- FETCH_BTB_EN defined: BTB is present and behaves as described above.
- FETCH_BTB_EN undefined:
  - No BTB storage.
  - Next PC is PC+4 unless stalled or redirected.
  - if_id_pred_taken is tied to 0.
  - upd_* inputs are ignored.
  - BTB_DEPTH has no effect.

## Test plan
- Reset asserted, then released with stall=0:
  - While in reset: pc_out=0, if_id_valid=0.
  - After release: pc_out=0,4,8 on successive cycles; if_id_pc trails by 1 cycle; if_id_pc_plus4=if_id_pc+4.
- stall high for 2 cycles at pc_out=0x8: pc_out stays 0x8, IF/ID frozen; fetch resumes with 0xC afterwards.
- redirect_valid with redirect_pc=0x103 while stall=1:
  - Next cycle: pc_out=0x100, if_id_valid=0.
  - Cycle after: if_id_pc=0x100, if_id_valid=1.
- BTB training (FETCH_BTB_EN): upd pc=0x10, taken, target=0x40, then fetch reaches 0x10:
  - Next pc_out=0x40.
  - IF/ID holds pc=0x10 with if_id_pred_taken=1.
  - Two further not-taken updates for 0x10 move the counter 10→01→00; fetch of 0x10 is then followed by 0x14 with pred_taken=0.
- Same-cycle lookup and update at pc_out=0x10 (index 4) with upd pc=0x10 taken: that cycle predicts from the old entry; the following cycle sees the new one.
- RESET_PC=0xFFFF_FFFC, no stall: pc_out=0xFFFF_FFFC then 0x0000_0000 (wrap-around).
